// File: rtl/regbank_write_arbiter_if.sv
// regbank_write_arbiter_if: two-source writeback handshake plus register bank write port
// Ports (signals):
//   a_valid/a_address/a_data, a_ready : src A (ALU result) offer and slot-ready
//   b_valid/b_address/b_data, b_ready : src B (memory load) offer and slot-ready
//   write/write_address/write_data    : registered register bank write port
//   busy                              : either holding slot occupied
// Modports: master = sources and bank side, slave = arbiter.
interface regbank_write_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
);
   logic                  a_valid;
   logic [ADDR_WIDTH-1:0] a_address;
   logic [DATA_WIDTH-1:0] a_data;
   logic                  a_ready;
   logic                  b_valid;
   logic [ADDR_WIDTH-1:0] b_address;
   logic [DATA_WIDTH-1:0] b_data;
   logic                  b_ready;
   logic                  write;
   logic [ADDR_WIDTH-1:0] write_address;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  busy;
   modport master (
      output a_valid, a_address, a_data, b_valid, b_address, b_data,
      input  a_ready, b_ready, write, write_address, write_data, busy
   );
   modport slave (
      input  a_valid, a_address, a_data, b_valid, b_address, b_data,
      output a_ready, b_ready, write, write_address, write_data, busy
   );
endinterface

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: shares one register bank write port between ALU (A) and load (B) writebacks
// Ports: clock, reset (sync, active-high); bus (regbank_write_arbiter_if.slave) carrying
//   both source handshakes, the registered write/write_address/write_data and busy.
// Optional: REGBANK_XZR_DISCARD_EN drops accepted writes to the all-ones register (XZR).
module regbank_write_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
) (
   input logic clock,
   input logic reset,
   regbank_write_arbiter_if.slave bus
);
`ifdef REGBANK_XZR_DISCARD_EN
   localparam logic XZR_DISCARD = 1'b1;
`else
   localparam logic XZR_DISCARD = 1'b0;
`endif
   logic                  slot_a_valid, slot_b_valid;
   logic [ADDR_WIDTH-1:0] slot_a_address, slot_b_address;
   logic [DATA_WIDTH-1:0] slot_a_data, slot_b_data;
   logic                  young_a, young_b, ptr_b;
   logic                  tie, grant_a, grant_b, keep_a, keep_b;
   logic                  take_a, take_b, load_a, load_b;
   // A slot is only ever younger for the single cycle it waits behind the
   // older one, since exactly one grant is taken whenever both are occupied.
   always_comb begin
      tie          = slot_a_valid & slot_b_valid & !young_a & !young_b;
      grant_a      = slot_a_valid & (!slot_b_valid | young_b | (tie & !ptr_b));
      grant_b      = slot_b_valid & !grant_a;
      keep_a       = slot_a_valid & !grant_a;
      keep_b       = slot_b_valid & !grant_b;
      bus.a_ready  = !reset & (!slot_a_valid | grant_a);
      bus.b_ready  = !reset & (!slot_b_valid | grant_b);
      take_a       = bus.a_valid & bus.a_ready;
      take_b       = bus.b_valid & bus.b_ready;
      load_a       = take_a & !(XZR_DISCARD & (&bus.a_address));
      load_b       = take_b & !(XZR_DISCARD & (&bus.b_address));
      bus.busy     = slot_a_valid | slot_b_valid;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         slot_a_valid      <= 1'b0;
         slot_b_valid      <= 1'b0;
         young_a           <= 1'b0;
         young_b           <= 1'b0;
         ptr_b             <= 1'b0;
         bus.write         <= 1'b0;
         bus.write_address <= '0;
         bus.write_data    <= '0;
      end else begin
         bus.write <= grant_a | grant_b;
         if (grant_a | grant_b) begin
            bus.write_address <= grant_a ? slot_a_address : slot_b_address;
            bus.write_data    <= grant_a ? slot_a_data : slot_b_data;
         end
         if (tie) ptr_b <= !ptr_b;
         slot_a_valid <= load_a | keep_a;
         slot_b_valid <= load_b | keep_b;
         young_a      <= load_a & keep_b;
         young_b      <= load_b & keep_a;
         if (load_a) begin
            slot_a_address <= bus.a_address;
            slot_a_data    <= bus.a_data;
         end
         if (load_b) begin
            slot_b_address <= bus.b_address;
            slot_b_data    <= bus.b_data;
         end
      end
   end
endmodule
